id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32 core.
- Feeds the EX stage and supplies the EX-stage rs1/rs2/Rd indices consumed by the forwarding unit.
- Contains load-use hazard detection: it inserts a one-cycle bubble and raises a stall to hold the PC and the IF/ID register.
- Keeps a saturating count of load-use stall cycles for performance monitoring.

Parameters:
XLEN, 32, datapath width of register operands and immediate
CNT_WIDTH, 32, width of the stall-cycle counter

Ports:
clk_i  input  1  core clock; all state updates on rising edge
rst_i  input  1  synchronous, active-low reset
Flush_i  input  1  squash the ID-stage instruction (taken branch); a bubble enters EX
ID_valid_i  input  1  ID stage holds a real instruction
ID_RegWrite_i  input  1  control: write register file
ID_MemtoReg_i  input  1  control: writeback selects memory data
ID_MemRead_i  input  1  control: load
ID_MemWrite_i  input  1  control: store
ID_ALUOp_i  input  2  control: ALU operation class
ID_ALUSrc_i  input  1  control: ALU operand B selects the immediate
ID_use_rs1_i  input  1  instruction reads rs1
ID_use_rs2_i  input  1  instruction reads rs2
ID_RS1data_i  input  XLEN  register file read data 1
ID_RS2data_i  input  XLEN  register file read data 2
ID_imm_i  input  XLEN  sign-extended immediate
ID_funct_i  input  10  {funct7, funct3}
ID_rs1_i  input  5  source register 1 index
ID_rs2_i  input  5  source register 2 index
ID_Rd_i  input  5  destination register index
EX_valid_o  output  1  EX stage holds a real instruction
EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o  output  1 each  registered control
EX_ALUOp_o  output  2  registered ALUOp
EX_RS1data_o, EX_RS2data_o, EX_imm_o  output  XLEN each  registered operands
EX_funct_o  output  10  registered funct
EX_rs1_o, EX_rs2_o, EX_Rd_o  output  5 each  registered indices (rs1/rs2 go to the forwarding unit)
Stall_o  output  1  combinational; hold PC and IF/ID this cycle
stall_cnt_o  output  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (rst_i==0 at a rising edge): every registered output clears to 0, including stall_cnt_o. Stall_o is forced to 0 while rst_i==0.
- Hazard term, combinational: hz = ID_valid_i & EX_valid_o & EX_MemRead_o & (EX_Rd_o!=0) & ((ID_use_rs1_i & EX_Rd_o==ID_rs1_i) | (ID_use_rs2_i & EX_Rd_o==ID_rs2_i)).
- Stall_o = rst_i & hz & ~Flush_i. Flush overrides the stall because the instruction in ID is being discarded anyway.
- Register update priority at each rising edge: reset > Flush_i > Stall_o (bubble) > normal capture.
- Bubble: EX_valid_o and all control, data, index and funct outputs load 0. A bubble therefore never writes, never accesses memory, and has Rd=x0, so it causes no forwarding.
- Normal capture: every EX_* output loads its ID_* counterpart. EX_valid_o loads ID_valid_i. Latency is exactly one cycle.
- Load-use stall lasts exactly one cycle. After the bubble, EX_MemRead_o==0, so hz drops. The held instruction is captured on the next edge; the forwarding unit then supplies the load data from WB.
- A back-to-back load followed by a dependent load stalls once per dependency. No deadlock is possible.
- stall_cnt_o increments by 1 on each edge where Stall_o==1. It saturates at all-ones and never wraps. It is not incremented when Flush_i suppresses the stall.
- Reset asserted mid-stall: the next edge clears all state and the stall does not persist.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with random ID inputs -> all EX_* outputs=0, Stall_o=0, stall_cnt_o=0.
- Normal capture: ID_Rd_i=5, ID_RS1data_i=32'hDEADBEEF, RegWrite=1, no hazard -> one edge later EX_Rd_o=5, EX_RS1data_o=32'hDEADBEEF, EX_RegWrite_o=1, EX_valid_o=1.
- Load-use: EX holds a load with Rd=7; ID has rs1=7, use_rs1=1 -> Stall_o=1 that cycle. Next edge: bubble in EX (all 0), stall_cnt_o=1. Following edge: the dependent instruction is captured with EX_rs1_o=7.
- No false stall: load with Rd=7 and ID rs2=7 but use_rs2=0 -> Stall_o=0. Load with Rd=0 and ID rs1=0 -> Stall_o=0.
- Flush with hazard: load-use condition plus Flush_i=1 -> Stall_o=0, bubble captured, stall_cnt_o unchanged.
- Saturation: CNT_WIDTH=3, force 9 stall cycles -> stall_cnt_o reaches 3'b111 and stays there.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection
// and a saturating stall-cycle counter.
module id_ex_stage_reg #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 Flush_i,
  input  logic                 ID_valid_i,
  input  logic                 ID_RegWrite_i,
  input  logic                 ID_MemtoReg_i,
  input  logic                 ID_MemRead_i,
  input  logic                 ID_MemWrite_i,
  input  logic [1:0]           ID_ALUOp_i,
  input  logic                 ID_ALUSrc_i,
  input  logic                 ID_use_rs1_i,
  input  logic                 ID_use_rs2_i,
  input  logic [XLEN-1:0]      ID_RS1data_i,
  input  logic [XLEN-1:0]      ID_RS2data_i,
  input  logic [XLEN-1:0]      ID_imm_i,
  input  logic [9:0]           ID_funct_i,
  input  logic [4:0]           ID_rs1_i,
  input  logic [4:0]           ID_rs2_i,
  input  logic [4:0]           ID_Rd_i,
  output logic                 EX_valid_o,
  output logic                 EX_RegWrite_o,
  output logic                 EX_MemtoReg_o,
  output logic                 EX_MemRead_o,
  output logic                 EX_MemWrite_o,
  output logic                 EX_ALUSrc_o,
  output logic [1:0]           EX_ALUOp_o,
  output logic [XLEN-1:0]      EX_RS1data_o,
  output logic [XLEN-1:0]      EX_RS2data_o,
  output logic [XLEN-1:0]      EX_imm_o,
  output logic [9:0]           EX_funct_o,
  output logic [4:0]           EX_rs1_o,
  output logic [4:0]           EX_rs2_o,
  output logic [4:0]           EX_Rd_o,
  output logic                 Stall_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [9:0]      funct;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  id_ex_t               r_ex;
  id_ex_t               w_id;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_rs1_hit;
  logic                 w_rs2_hit;
  logic                 w_hz;
  logic                 w_stall;

  assign w_id = '{
    valid:      ID_valid_i,
    reg_write:  ID_RegWrite_i,
    mem_to_reg: ID_MemtoReg_i,
    mem_read:   ID_MemRead_i,
    mem_write:  ID_MemWrite_i,
    alu_src:    ID_ALUSrc_i,
    alu_op:     ID_ALUOp_i,
    rs1_data:   ID_RS1data_i,
    rs2_data:   ID_RS2data_i,
    imm:        ID_imm_i,
    funct:      ID_funct_i,
    rs1:        ID_rs1_i,
    rs2:        ID_rs2_i,
    rd:         ID_Rd_i
  };

  assign w_rs1_hit = ID_use_rs1_i & (r_ex.rd == ID_rs1_i);
  assign w_rs2_hit = ID_use_rs2_i & (r_ex.rd == ID_rs2_i);

  assign w_hz = ID_valid_i & r_ex.valid & r_ex.mem_read
              & (r_ex.rd != 5'd0)
              & (w_rs1_hit | w_rs2_hit);

  // a flushed ID instruction is discarded, so it never needs to wait
  assign w_stall = rst_i & w_hz & ~Flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ex <= '0;
    end else if (Flush_i || w_stall) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign EX_valid_o    = r_ex.valid;
  assign EX_RegWrite_o = r_ex.reg_write;
  assign EX_MemtoReg_o = r_ex.mem_to_reg;
  assign EX_MemRead_o  = r_ex.mem_read;
  assign EX_MemWrite_o = r_ex.mem_write;
  assign EX_ALUSrc_o   = r_ex.alu_src;
  assign EX_ALUOp_o    = r_ex.alu_op;
  assign EX_RS1data_o  = r_ex.rs1_data;
  assign EX_RS2data_o  = r_ex.rs2_data;
  assign EX_imm_o      = r_ex.imm;
  assign EX_funct_o    = r_ex.funct;
  assign EX_rs1_o      = r_ex.rs1;
  assign EX_rs2_o      = r_ex.rs2;
  assign EX_Rd_o       = r_ex.rd;
  assign Stall_o       = w_stall;
  assign stall_cnt_o   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg,
// checked against a rule-level model of the EX slot.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid, id_rw, id_m2r, id_mr, id_mw;
  logic [1:0]  id_aluop;
  logic        id_alusrc, use1, use2;
  logic [31:0] id_d1, id_d2, id_imm;
  logic [9:0]  id_funct;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic        ex_valid, ex_rw, ex_m2r, ex_mr, ex_mw, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [9:0]  ex_funct;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        stall;
  logic [31:0] cnt;

  logic        s_valid, s_rw, s_m2r, s_mr, s_mw, s_alusrc;
  logic [1:0]  s_aluop;
  logic [31:0] s_d1, s_d2, s_imm;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_stall;
  logic [2:0]  cnt3;

  ex_t dut_ex, dut_s_ex, id_b;
  ex_t m_ex;
  int unsigned m_cnt;
  int          m_cnt3;
  int          errors = 0;
  int          checks = 0;

  assign dut_ex = {ex_valid, ex_rw, ex_m2r, ex_mr, ex_mw, ex_alusrc,
                   ex_aluop, ex_d1, ex_d2, ex_imm, ex_funct,
                   ex_rs1, ex_rs2, ex_rd};
  assign dut_s_ex = {s_valid, s_rw, s_m2r, s_mr, s_mw, s_alusrc,
                     s_aluop, s_d1, s_d2, s_imm, s_funct,
                     s_rs1, s_rs2, s_rd};
  assign id_b = {id_valid, id_rw, id_m2r, id_mr, id_mw, id_alusrc,
                 id_aluop, id_d1, id_d2, id_imm, id_funct,
                 id_rs1, id_rs2, id_rd};

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i(clk), .rst_i(rst), .Flush_i(flush),
    .ID_valid_i(id_valid), .ID_RegWrite_i(id_rw),
    .ID_MemtoReg_i(id_m2r), .ID_MemRead_i(id_mr),
    .ID_MemWrite_i(id_mw), .ID_ALUOp_i(id_aluop),
    .ID_ALUSrc_i(id_alusrc), .ID_use_rs1_i(use1),
    .ID_use_rs2_i(use2), .ID_RS1data_i(id_d1),
    .ID_RS2data_i(id_d2), .ID_imm_i(id_imm),
    .ID_funct_i(id_funct), .ID_rs1_i(id_rs1),
    .ID_rs2_i(id_rs2), .ID_Rd_i(id_rd),
    .EX_valid_o(ex_valid), .EX_RegWrite_o(ex_rw),
    .EX_MemtoReg_o(ex_m2r), .EX_MemRead_o(ex_mr),
    .EX_MemWrite_o(ex_mw), .EX_ALUSrc_o(ex_alusrc),
    .EX_ALUOp_o(ex_aluop), .EX_RS1data_o(ex_d1),
    .EX_RS2data_o(ex_d2), .EX_imm_o(ex_imm),
    .EX_funct_o(ex_funct), .EX_rs1_o(ex_rs1),
    .EX_rs2_o(ex_rs2), .EX_Rd_o(ex_rd),
    .Stall_o(stall), .stall_cnt_o(cnt)
  );

  id_ex_stage_reg #(.XLEN(32), .CNT_WIDTH(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .Flush_i(flush),
    .ID_valid_i(id_valid), .ID_RegWrite_i(id_rw),
    .ID_MemtoReg_i(id_m2r), .ID_MemRead_i(id_mr),
    .ID_MemWrite_i(id_mw), .ID_ALUOp_i(id_aluop),
    .ID_ALUSrc_i(id_alusrc), .ID_use_rs1_i(use1),
    .ID_use_rs2_i(use2), .ID_RS1data_i(id_d1),
    .ID_RS2data_i(id_d2), .ID_imm_i(id_imm),
    .ID_funct_i(id_funct), .ID_rs1_i(id_rs1),
    .ID_rs2_i(id_rs2), .ID_Rd_i(id_rd),
    .EX_valid_o(s_valid), .EX_RegWrite_o(s_rw),
    .EX_MemtoReg_o(s_m2r), .EX_MemRead_o(s_mr),
    .EX_MemWrite_o(s_mw), .EX_ALUSrc_o(s_alusrc),
    .EX_ALUOp_o(s_aluop), .EX_RS1data_o(s_d1),
    .EX_RS2data_o(s_d2), .EX_imm_o(s_imm),
    .EX_funct_o(s_funct), .EX_rs1_o(s_rs1),
    .EX_rs2_o(s_rs2), .EX_Rd_o(s_rd),
    .Stall_o(s_stall), .stall_cnt_o(cnt3)
  );

  // Load in EX whose nonzero Rd is read by a live ID instruction
  function automatic logic model_stall();
    logic dep;
    dep = (use1 && m_ex.rd == id_rs1) || (use2 && m_ex.rd == id_rs2);
    return rst && !flush && id_valid && m_ex.valid && m_ex.mr
           && m_ex.rd != 5'd0 && dep;
  endfunction

  task automatic step();
    logic st;
    @(posedge clk);
    st = model_stall();
    if (!rst) begin
      m_ex = '0;
      m_cnt = 0;
      m_cnt3 = 0;
    end else begin
      if (st) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
      end
      m_ex = (flush || st) ? '0 : id_b;
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; id_rw = 0; id_m2r = 0;
    id_mr = 0; id_mw = 0; id_aluop = 0; id_alusrc = 0;
    use1 = 0; use2 = 0; id_d1 = 0; id_d2 = 0; id_imm = 0;
    id_funct = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic drive_rand();
    id_valid = $urandom_range(0, 3) != 0;
    id_rw = 1'($urandom); id_m2r = 1'($urandom);
    id_mr = 1'($urandom); id_mw = 1'($urandom);
    id_aluop = 2'($urandom); id_alusrc = 1'($urandom);
    use1 = 1'($urandom); use2 = 1'($urandom);
    id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom;
    id_funct = 10'($urandom);
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle();
    id_valid = 1; id_mr = 1; id_rw = 1; id_m2r = 1;
    id_rd = rd; id_rs1 = 5'd2; use1 = 1;
  endtask

  task automatic drive_user(input logic [4:0] rs1,
                            input logic [4:0] rd);
    idle();
    id_valid = 1; id_rw = 1; use1 = 1;
    id_rs1 = rs1; id_rs2 = 5'd30; id_rd = rd;
    id_d1 = 32'h1234_5678;
  endtask

  task automatic test_reset();
    rst = 0;
    flush = 1'($urandom);
    drive_rand();
    step();
    drive_rand();
    step();
    checks++;
    if (dut_ex !== '0) begin
      errors++;
      $display("FAIL reset_ex got=%h want=0", dut_ex);
    end
    checks++;
    if (stall !== 1'b0 || s_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b/%b want=0", stall, s_stall);
    end
    checks++;
    if (cnt !== 32'd0 || cnt3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d want=0", cnt, cnt3);
    end
    rst = 1;
    idle();
    step();
  endtask

  task automatic test_capture();
    idle();
    id_valid = 1; id_rw = 1; id_rd = 5'd5;
    id_d1 = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL capture_stall got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_rd !== 5'd5 || ex_d1 !== 32'hDEADBEEF ||
        ex_rw !== 1'b1 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture got rd=%0d d1=%h rw=%b v=%b want 5 DEADBEEF 1 1",
               ex_rd, ex_d1, ex_rw, ex_valid);
    end
    checks++;
    if (dut_ex !== m_ex) begin
      errors++;
      $display("FAIL capture_all got=%h want=%h", dut_ex, m_ex);
    end
  endtask

  task automatic test_load_use();
    int unsigned pre;
    drive_load(5'd7);
    step();
    drive_user(5'd7, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_stall got=%b want=1", stall);
    end
    pre = m_cnt;
    step();
    checks++;
    if (dut_ex !== '0) begin
      errors++;
      $display("FAIL loaduse_bubble got=%h want=0", dut_ex);
    end
    checks++;
    if (cnt !== pre + 1) begin
      errors++;
      $display("FAIL loaduse_cnt got=%0d want=%0d", cnt, pre + 1);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_release got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_rs1 !== 5'd7 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
      errors++;
      $display("FAIL loaduse_capture got rs1=%0d v=%b rd=%0d want 7 1 3",
               ex_rs1, ex_valid, ex_rd);
    end
  endtask

  task automatic test_no_false_stall();
    drive_load(5'd7);
    step();
    idle();
    id_valid = 1; id_rs2 = 5'd7; use2 = 0;
    id_rs1 = 5'd4; use1 = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL nofalse_rs2 got=%b want=0", stall);
    end
    drive_load(5'd0);
    step();
    idle();
    id_valid = 1; id_rs1 = 5'd0; use1 = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL nofalse_x0 got=%b want=0", stall);
    end
    step();
  endtask

  task automatic test_flush_hazard();
    int unsigned pre;
    drive_load(5'd7);
    step();
    drive_user(5'd7, 5'd9);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got=%b want=0", stall);
    end
    pre = m_cnt;
    step();
    checks++;
    if (dut_ex !== '0 || cnt !== pre) begin
      errors++;
      $display("FAIL flush_bubble got ex=%h cnt=%0d want 0 %0d",
               dut_ex, cnt, pre);
    end
    flush = 0;
  endtask

  task automatic test_back_to_back();
    int nst = 0;
    drive_load(5'd7);
    step();
    drive_load(5'd8);
    id_rs1 = 5'd7;
    #1;
    if (stall === 1'b1) nst++;
    step();
    step();
    drive_user(5'd8, 5'd1);
    #1;
    if (stall === 1'b1) nst++;
    step();
    step();
    checks++;
    if (nst != 2 || ex_rs1 !== 5'd8 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL back2back stalls=%0d rs1=%0d want 2 8", nst, ex_rs1);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      drive_load(5'd9);
      step();
      drive_user(5'd9, 5'd2);
      step();
      step();
    end
    checks++;
    if (cnt3 !== 3'b111) begin
      errors++;
      $display("FAIL sat_cnt3 got=%b want=111", cnt3);
    end
    drive_load(5'd9);
    step();
    drive_user(5'd9, 5'd2);
    step();
    checks++;
    if (cnt3 !== 3'b111 || cnt !== m_cnt) begin
      errors++;
      $display("FAIL sat_hold got=%b/%0d want=111/%0d", cnt3, cnt, m_cnt);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      rst = $urandom_range(0, 39) != 0;
      flush = $urandom_range(0, 7) == 0;
      #1;
      checks++;
      if (stall !== model_stall() || s_stall !== model_stall()) begin
        errors++;
        $display("FAIL rand_stall[%0d] got=%b/%b want=%b",
                 i, stall, s_stall, model_stall());
      end
      step();
      checks++;
      if (dut_ex !== m_ex || dut_s_ex !== m_ex) begin
        errors++;
        $display("FAIL rand_ex[%0d] got=%h want=%h", i, dut_ex, m_ex);
      end
      checks++;
      if (cnt !== m_cnt || cnt3 !== 3'(m_cnt3)) begin
        errors++;
        $display("FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                 i, cnt, cnt3, m_cnt, m_cnt3);
      end
    end
    rst = 1;
  endtask

  initial begin
    m_ex = '0;
    m_cnt = 0;
    m_cnt3 = 0;
    idle();
    rst = 0;
    test_reset();
    test_capture();
    test_load_use();
    test_no_false_stall();
    test_flush_hazard();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
